fetch_issue_unit: RTL

//  Downstream consumer of the BPU fetch target queue. Pops predicted fetch blocks
//  (pc, queue ptr, inst count), issues 16-byte-aligned I-cache reads, holds

---
 rtl/fetch_issue_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit
//   Consumes predicted fetch blocks from the BPU fetch target queue, issues
//   16-byte-aligned I-cache reads, keeps returned lines in an in-order slot
//   ring and hands {pc, ptr, num, data, err} to predecode. A flush empties the
//   ring and swallows the responses still owed by the cache before issuing
//   again.
// Ports
//   Clk, Rest                 clock (rising edge), async active-low reset
//   FetchTQStop/FetchTQFlash  block new issues / flush everything
//   Bq*                       BPU queue head (BqReady = pop)
//   IcReq*/IcResp*            I-cache request (valid/ready) and in-order response
//   Fb*                       head-slot delivery to predecode (valid/ready)
//   Busy                      slots occupied or responses still to be dropped

// Protocol checker: a response must always have an unfilled slot to land in.
module fetch_issue_unit_chk (
    input logic Clk,
    input logic Rest,
    input logic resp_orphan_s
);
    orphan_resp_a: assert property (@(posedge Clk) disable iff (!Rest) !resp_orphan_s);
endmodule

module fetch_issue_unit #(
    parameter int ADDR_W = 32,
    parameter int OUTST  = 4,
    parameter int PTR_W  = 6
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              FetchTQStop,
    input  logic              FetchTQFlash,
    input  logic              BqValid,
    output logic              BqReady,
    input  logic [ADDR_W-1:0] BqPc,
    input  logic [PTR_W-1:0]  BqPtr,
    input  logic [2:0]        BqNum,
    output logic              IcReqValid,
    input  logic              IcReqReady,
    output logic [ADDR_W-1:0] IcReqAddr,
    input  logic              IcRespValid,
    input  logic [127:0]      IcRespData,
    input  logic              IcRespErr,
    output logic              FbValid,
    input  logic              FbReady,
    output logic [ADDR_W-1:0] FbPc,
    output logic [PTR_W-1:0]  FbPtr,
    output logic [2:0]        FbNum,
    output logic [127:0]      FbData,
    output logic              FbErr,
    output logic              Busy
);
    localparam int IDX_W = $clog2(OUTST);
    localparam int CNT_W = $clog2(OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTST);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e            state_r, state_s;
    logic              live_r;
    logic [IDX_W-1:0]  head_r, tail_r, fill_r;
    logic [CNT_W-1:0]  cnt_r, ufl_r, drop_r, drop_s, ufl_next_s;
    logic [OUTST-1:0]  filled_r;
    logic [ADDR_W-1:0] pc_r   [OUTST];
    logic [PTR_W-1:0]  ptr_r  [OUTST];
    logic [2:0]        num_r  [OUTST];
    logic [127:0]      data_r [OUTST];
    logic              err_r  [OUTST];

    logic run_s, issue_fire_s, resp_fire_s, resp_drop_s, resp_orphan_s, pop_s;

    // live_r keeps the request path quiet while Rest is low and for the first
    // edge after release, so every output reads 0 during reset.
    assign run_s         = (state_r == ST_RUN);
    assign IcReqValid    = live_r & BqValid & run_s & ~FetchTQStop
                         & (cnt_r < CNT_FULL) & ~FetchTQFlash;
    assign issue_fire_s  = IcReqValid & IcReqReady;
    assign BqReady       = issue_fire_s;
    assign IcReqAddr     = IcReqValid ? {BqPc[ADDR_W-1:4], 4'b0000} : {ADDR_W{1'b0}};

    // ufl_r counts issued slots still waiting for their line.
    assign resp_fire_s   = IcRespValid & run_s & (ufl_r != CNT_ZERO);
    assign resp_drop_s   = IcRespValid & ~run_s & (drop_r != CNT_ZERO);
    assign resp_orphan_s = IcRespValid & run_s & (ufl_r == CNT_ZERO);
    assign ufl_next_s    = ufl_r + CNT_W'(issue_fire_s) - CNT_W'(resp_fire_s);

    // A pop in the flush cycle is void: the slot contents are discarded.
    assign FbValid = filled_r[head_r];
    assign pop_s   = FbValid & FbReady & ~FetchTQFlash;
    assign FbPc    = FbValid ? pc_r[head_r]   : {ADDR_W{1'b0}};
    assign FbPtr   = FbValid ? ptr_r[head_r]  : {PTR_W{1'b0}};
    assign FbNum   = FbValid ? num_r[head_r]  : 3'b000;
    assign FbData  = FbValid ? data_r[head_r] : {128{1'b0}};
    assign FbErr   = FbValid ? err_r[head_r]  : 1'b0;
    assign Busy    = (cnt_r != CNT_ZERO) | (drop_r != CNT_ZERO);

    // Next FSM state and drop counter; a flush in RUN turns every response
    // still owed (including this cycle's accounting) into one to discard.
    always_comb begin
        state_s = state_r;
        drop_s  = drop_r;
        case (state_r)
            ST_RUN: begin
                if (FetchTQFlash) begin
                    drop_s = ufl_next_s;
                    if (ufl_next_s != CNT_ZERO) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (resp_drop_s) begin
                    drop_s = drop_r - CNT_ONE;
                end else begin
                    drop_s = drop_r;
                end
                if (drop_s == CNT_ZERO) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_RUN;
                drop_s  = CNT_ZERO;
            end
        endcase
    end

    // FSM state, drop counter and out-of-reset flag
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state_r <= ST_RUN;
            drop_r  <= CNT_ZERO;
            live_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            drop_r  <= drop_s;
            live_r  <= 1'b1;
        end
    end

    // Ring pointers and occupancy counters; a flush empties the ring
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            head_r <= IDX_ZERO;
            tail_r <= IDX_ZERO;
            fill_r <= IDX_ZERO;
            cnt_r  <= CNT_ZERO;
            ufl_r  <= CNT_ZERO;
        end else if (FetchTQFlash) begin
            head_r <= IDX_ZERO;
            tail_r <= IDX_ZERO;
            fill_r <= IDX_ZERO;
            cnt_r  <= CNT_ZERO;
            ufl_r  <= CNT_ZERO;
        end else begin
            if (issue_fire_s) tail_r <= tail_r + IDX_ONE;
            if (resp_fire_s)  fill_r <= fill_r + IDX_ONE;
            if (pop_s)        head_r <= head_r + IDX_ONE;
            cnt_r <= cnt_r + CNT_W'(issue_fire_s) - CNT_W'(pop_s);
            ufl_r <= ufl_next_s;
        end
    end

    // Per-slot filled flags: set by a response, cleared by delivery or flush
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            filled_r <= {OUTST{1'b0}};
        end else if (FetchTQFlash) begin
            filled_r <= {OUTST{1'b0}};
        end else begin
            if (pop_s)       filled_r[head_r] <= 1'b0;
            if (resp_fire_s) filled_r[fill_r] <= 1'b1;
        end
    end

    // Slot payload; only ever observed through a filled flag, so no reset
    always_ff @(posedge Clk) begin
        if (issue_fire_s) begin
            pc_r[tail_r]  <= BqPc;
            ptr_r[tail_r] <= BqPtr;
            num_r[tail_r] <= BqNum;
        end
        if (resp_fire_s) begin
            data_r[fill_r] <= IcRespData;
            err_r[fill_r]  <= IcRespErr;
        end
    end

    fetch_issue_unit_chk u_chk (
        .Clk           (Clk),
        .Rest          (Rest),
        .resp_orphan_s (resp_orphan_s)
    );
endmodule
